// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and frame-field constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes (LSB first) into 32-bit words and emits a
// one-cycle word_valid pulse the cycle after the fourth byte is accepted.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_idx;
    logic [31:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;
    logic [31:0] w_next;

    assign w_next       = {i_byte, r_shift[31:8]};
    assign o_last       = (r_idx == 2'(WORD_BYTES - 1));
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_idx   <= '0;
                r_shift <= '0;
            end else if (i_accept) begin
                r_shift <= w_next;
                r_idx   <= r_idx + 2'd1;
                // The completed word is latched so it stays stable while the
                // next word starts shifting in during the write strobe.
                if (o_last) begin
                    r_word       <= w_next;
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the CPU instruction memory: parses length,
// writes words at consecutive addresses, verifies the XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter int unsigned             MAX_WORDS  = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_csum;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [15:0]           r_count;

    logic                  w_accept;
    logic                  w_data_accept;
    logic                  w_start_ok;
    logic [15:0]           w_len;
    logic [15:0]           w_count_next;
    logic                  w_last_byte;
    logic                  w_word_valid;
    logic [31:0]           w_word;

    assign w_accept      = in_valid && r_in_ready;
    assign w_data_accept = w_accept && (r_state == ST_DATA);
    assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                     (r_state == ST_ERR));
    assign w_len         = {in_data, r_len_lo};
    assign w_count_next  = r_count + 16'd1;

    imem_loader_byte_packer u_packer (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear      (w_start_ok),
        .i_accept     (w_data_accept),
        .i_byte       (in_data),
        .o_last       (w_last_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    assign in_ready  = r_in_ready;
    assign mem_we    = w_word_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = w_word;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_mem_addr <= BASE_ADDR;
            r_csum     <= '0;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept)
                r_csum <= r_csum ^ in_data;
            // Address steps after each strobe and simply wraps at the top.
            if (w_word_valid)
                r_mem_addr <= r_mem_addr + ADDR_WIDTH'(WORD_BYTES);

            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_start_ok) begin
                        r_state    <= ST_LEN_LO;
                        r_csum     <= '0;
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_mem_addr <= BASE_ADDR;
                        r_cpu_hold <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= in_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (32'(w_len) > MAX_WORDS) begin
                            r_state    <= ST_ERR;
                            r_error    <= 1'b1;
                            r_in_ready <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_data_accept && w_last_byte) begin
                        r_count <= w_count_next;
                        if (w_count_next == r_len)
                            r_state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_csum) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus
// randomized frames scored against a frame-level reference model.
module tb_imem_loader;

    localparam int unsigned TB_MAX = 4;
    localparam logic [63:0] TB_BASE = 64'd0;

    typedef logic [7:0] bytes_t[$];

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int passes = 0;

    logic [63:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [63:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic        exp_done;
    logic        exp_err;

    imem_loader #(
        .ADDR_WIDTH (64),
        .BASE_ADDR  (TB_BASE),
        .MAX_WORDS  (TB_MAX)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
    end

    // Reference model: decode the frame from its definition.
    function automatic void model(input bytes_t b);
        int unsigned n;
        logic [7:0]  x;
        exp_a.delete();
        exp_d.delete();
        n = int'(b[0]) | (int'(b[1]) << 8);
        if (n > TB_MAX) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int k = 0; k < int'(n); k++) begin
            exp_a.push_back(TB_BASE + 64'(4 * k));
            exp_d.push_back({b[2+4*k+3], b[2+4*k+2], b[2+4*k+1], b[2+4*k]});
        end
        x = 8'h00;
        for (int i = 0; i < b.size() - 1; i++)
            x = x ^ b[i];
        exp_done = (b[b.size()-1] == x);
        exp_err  = !exp_done;
    endfunction

    function automatic bytes_t make_frame(input int unsigned n, input bit bad);
        bytes_t     b;
        logic [7:0] x;
        b.push_back(n[7:0]);
        b.push_back(n[15:8]);
        if (n > TB_MAX)
            return b;
        for (int i = 0; i < int'(4 * n); i++)
            b.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        foreach (b[i])
            x = x ^ b[i];
        b.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
        return b;
    endfunction

    task automatic drive_byte(input logic [7:0] v, input int gap, output bit ok);
        int budget;
        if (gap > 0) begin
            @(negedge clock);
            in_valid = 1'b0;
            repeat (gap - 1) @(negedge clock);
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = v;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        ok = (in_ready === 1'b1);
    endtask

    task automatic run_frame(input bytes_t b, input int gap, input int mid_start,
                             input string name);
        bit ok;
        model(b);
        wr_a.delete();
        wr_d.delete();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if ({cpu_hold, in_ready} !== 2'b11)
            $display("FAIL %s start: hold/ready=%b expected 11", name, {cpu_hold, in_ready});
        else
            passes++;

        for (int i = 0; i < b.size(); i++) begin
            if (i == mid_start) begin
                @(negedge clock);
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clock);
                start    = 1'b0;
            end
            drive_byte(b[i], (i == 0) ? 0 : gap, ok);
            if (!ok) begin
                checks++;
                $display("FAIL %s byte %0d: in_ready never rose within 50 cycles", name, i);
                break;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;

        // Outcome is visible the cycle after the final byte is accepted.
        checks++;
        if ({done, error, cpu_hold} !== {exp_done, exp_err, exp_err})
            $display("FAIL %s outcome: done/error/hold=%b expected %b", name,
                     {done, error, cpu_hold}, {exp_done, exp_err, exp_err});
        else
            passes++;

        repeat (3) @(negedge clock);
        checks++;
        if ({in_ready, done, error} !== {1'b0, exp_done, exp_err})
            $display("FAIL %s hold: ready/done/error=%b expected %b", name,
                     {in_ready, done, error}, {1'b0, exp_done, exp_err});
        else
            passes++;

        checks++;
        if (wr_a.size() != exp_a.size())
            $display("FAIL %s write count: got %0d expected %0d", name, wr_a.size(), exp_a.size());
        else
            passes++;
        for (int k = 0; k < wr_a.size() && k < exp_a.size(); k++) begin
            checks++;
            if (wr_a[k] !== exp_a[k] || wr_d[k] !== exp_d[k])
                $display("FAIL %s write %0d: got %h@%h expected %h@%h", name, k,
                         wr_d[k], wr_a[k], exp_d[k], exp_a[k]);
            else
                passes++;
        end
    endtask

    function automatic bytes_t nominal(input logic [7:0] csum);
        bytes_t b;
        b = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h02, 8'h8B,
              8'h41, 8'h00, 8'h40, 8'hF8, csum};
        return b;
    endfunction

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        checks++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b0)
            $display("FAIL reset flags: got %b expected 00000",
                     {in_ready, mem_we, cpu_hold, done, error});
        else
            passes++;
        checks++;
        if (mem_addr !== TB_BASE || mem_wdata !== 32'h0)
            $display("FAIL reset bus: addr=%h data=%h expected %h/0", mem_addr, mem_wdata, TB_BASE);
        else
            passes++;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_nominal();
        run_frame(nominal(8'h52), 0, -1, "nominal");
        checks++;
        if (wr_d.size() == 2 && (wr_d[0] !== 32'h8B020020 || wr_d[1] !== 32'hF8400041))
            $display("FAIL nominal words: got %h %h expected 8b020020 f8400041", wr_d[0], wr_d[1]);
        else if (wr_d.size() != 2)
            $display("FAIL nominal words: got %0d writes expected 2", wr_d.size());
        else
            passes++;
    endtask

    task automatic test_bad_csum();
        run_frame(nominal(8'h53), 0, -1, "bad_csum");
    endtask

    task automatic test_oversize();
        bytes_t b;
        b = '{8'h05, 8'h00};
        run_frame(b, 0, -1, "oversize_5");
        b = '{8'hFF, 8'hFF};
        run_frame(b, 0, -1, "oversize_ffff");
        run_frame(make_frame(TB_MAX, 1'b0), 0, -1, "max_words");
    endtask

    task automatic test_zero_len();
        bytes_t b;
        b = '{8'h00, 8'h00, 8'h00};
        run_frame(b, 0, -1, "zero_len");
    endtask

    task automatic test_backpressure();
        run_frame(nominal(8'h52), 2, 6, "backpressure");
    endtask

    task automatic test_reset_mid_load();
        bytes_t b;
        bit     ok;
        b = nominal(8'h52);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 8; i++)
            drive_byte(b[i], 0, ok);
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b0)
            $display("FAIL mid_reset flags: got %b expected 00000",
                     {in_ready, mem_we, cpu_hold, done, error});
        else
            passes++;
        checks++;
        if (mem_addr !== TB_BASE || mem_wdata !== 32'h0)
            $display("FAIL mid_reset bus: addr=%h data=%h expected %h/0", mem_addr, mem_wdata, TB_BASE);
        else
            passes++;
        @(negedge clock);
        reset_n = 1'b1;
        run_frame(b, 0, -1, "after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int unsigned n;
            bit          bad;
            int          gap;
            n   = $urandom_range(0, TB_MAX + 1);
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 2);
            run_frame(make_frame(n, bad), gap, -1, $sformatf("random_%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_csum();
        test_oversize();
        test_zero_len();
        test_backpressure();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
